// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: DIFF = A - B, LSB first, one bit per clock.
// Each bit uses a half-subtractor pair plus a registered borrow.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic hs1_d, hs1_bo;
    logic dbit, hs2_bo;
    logic br_next;

    // First half subtractor: a0 - b0; second: (a0 - b0) - br.
    always_comb begin
        hs1_d   = a_q[0] ^ b_q[0];
        hs1_bo  = ~a_q[0] & b_q[0];
        dbit    = hs1_d ^ br_q;
        hs2_bo  = ~hs1_d & br_q;
        br_next = hs1_bo | hs2_bo;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE, FIN: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                // Shift the new difference bit in at the MSB; after WIDTH
                // steps bit 0 has reached the LSB.
                res_d = (res_q >> 1) | (WIDTH'(dbit) << (WIDTH - 1));
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d   = res_d;
                    borrow_d = br_next;
                    state_d  = FIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign BUSY   = (state_q == RUN);
    assign DONE   = (state_q == FIN);
    assign DIFF   = diff_q;
    assign BORROW = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1),
// reference model: {BORROW,DIFF} = {0,A} - {0,B} plus a fixed WIDTH+1 cycle period.
module tb_serial_subtractor;

    localparam int unsigned W = 8;
    localparam int unsigned P = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] diff;
    logic         borrow;

    logic         start1, a1, b1;
    logic         busy1, done1, diff1, borrow1;

    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;
    logic [W-1:0] prev_diff;
    logic         prev_borrow;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .CLK(clk), .RESET(rst), .START(start), .A(a), .B(b),
        .BUSY(busy), .DONE(done), .DIFF(diff), .BORROW(borrow)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .CLK(clk), .RESET(rst), .START(start1), .A(a1), .B(b1),
        .BUSY(busy1), .DONE(done1), .DIFF(diff1), .BORROW(borrow1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle (or in FIN); returns at a negedge with it idle.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W:0]  e;
        int unsigned cyc, nbusy, nchg;
        e     = {1'b0, av} - {1'b0, bv};
        start = 1'b1; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; nbusy = 0; nchg = 0;
        while (!done && cyc < W + 4) begin
            if (busy) nbusy++;
            if (diff !== prev_diff || borrow !== prev_borrow) nchg++;
            a = W'($urandom); b = W'($urandom);
            start = ($urandom_range(0, 3) == 0);
            cyc++;
            @(negedge clk);
            start = 1'b0;
        end
        check("done_seen", 32'(done), 32'd1);
        check("latency", cyc, W);
        check("busy_cycles", nbusy, W);
        check("held_during_run", nchg, 0);
        check("busy_at_done", 32'(busy), 32'd0);
        check("diff", 32'(diff), 32'(e[W-1:0]));
        check("borrow", 32'(borrow), 32'(e[W]));
        prev_diff   = e[W-1:0];
        prev_borrow = e[W];
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("diff_held", 32'(diff), 32'(prev_diff));
    endtask

    // START held high with operands changing every cycle: an operation is
    // accepted every P cycles using the operands present at that edge.
    task automatic back_to_back();
        logic [W:0] q[$];
        logic [W:0] e;
        for (int k = 0; k <= 3 * int'(P); k++) begin
            check("b2b_done", 32'(done), 32'((k > 0) && (k % int'(P) == 0)));
            if (k > 0 && k % int'(P) == 0) begin
                if (q.size() == 0) begin
                    check("b2b_queue", 32'd0, 32'd1);
                end else begin
                    e = q.pop_front();
                    check("b2b_diff", 32'(diff), 32'(e[W-1:0]));
                    check("b2b_borrow", 32'(borrow), 32'(e[W]));
                    prev_diff   = e[W-1:0];
                    prev_borrow = e[W];
                end
            end
            if (k == 3 * int'(P)) begin
                start = 1'b0;
            end else begin
                start = 1'b1;
                a = (k == 0) ? W'(8'h80) : W'($urandom);
                b = (k == 0) ? W'(8'h01) : W'($urandom);
                if (k % int'(P) == 0) q.push_back({1'b0, a} - {1'b0, b});
            end
            @(negedge clk);
        end
    endtask

    task automatic do_op1(input logic av, input logic bv);
        logic [1:0] e;
        e      = {1'b0, av} - {1'b0, bv};
        start1 = 1'b1; a1 = av; b1 = bv;
        @(negedge clk);
        start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom);
        check("w1_busy", 32'(busy1), 32'd1);
        check("w1_not_done", 32'(done1), 32'd0);
        @(negedge clk);
        check("w1_done", 32'(done1), 32'd1);
        check("w1_result", 32'({borrow1, diff1}), 32'(e));
    endtask

    initial begin
        int unsigned ndone;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        prev_diff = '0; prev_borrow = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_w1", 32'({busy1, done1, diff1, borrow1}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(8'h05, 8'h03);
        do_op(8'h03, 8'h05);
        do_op(8'h00, 8'h01);
        do_op(8'h00, 8'h00);
        do_op(8'hFF, 8'hFF);

        back_to_back();

        do_op(8'h80, 8'h01);
        do_op(8'h10, 8'h20);

        // Reset during the fourth RUN cycle aborts the operation.
        start = 1'b1; a = 8'h55; b = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow), 32'd0);
        ndone = 0;
        for (int i = 0; i < int'(W) + 3; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("abort_no_done", ndone, 0);
        prev_diff = '0; prev_borrow = 1'b0;
        do_op(8'hA7, 8'h3C);

        for (int i = 0; i < 1000; i++) do_op(W'($urandom), W'($urandom));

        for (int i = 0; i < 200; i++) do_op1(1'($urandom), 1'($urandom));
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
